// File: rtl/psum_glb_writer.sv
// psum_glb_writer
// Drains packed psum words (LANES psums per FIFO word) from the PE-array output
// FIFO and serializes them into single-psum writes on GLB port a. In accumulate
// mode each psum is first read back through GLB port b and the sum is written.
//
// Ports:
//   core_clk, reset            clock, async active-high reset
//   start, base_addr,
//   num_psums, accumulate      job request, sampled only when idle
//   fifo_empty, fifo_rdata,
//   fifo_re                    upstream FIFO (data valid the cycle after fifo_re)
//   glb_we_a/addr_a/wdata_a    GLB write port
//   glb_re_b/addr_b/rdata_b    GLB read port (data valid the cycle after glb_re_b)
//   busy, done                 job status; done pulses with the FIN state
//   sat_flag                   sticky clamp indicator (PSUM_WRITER_SAT_EN only)
//
// Optional build macro: PSUM_WRITER_SAT_EN selects saturating accumulation and
// adds the sat_flag port; otherwise accumulation wraps modulo 2^DATA_WIDTH.
module psum_glb_writer #(
    parameter int FIFO_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 193600,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR-1:0]       base_addr,
    input  logic [ADDR-1:0]       num_psums,
    input  logic                  accumulate,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_re,
    output logic                  glb_we_a,
    output logic [ADDR-1:0]       glb_addr_a,
    output logic [DATA_WIDTH-1:0] glb_wdata_a,
    output logic                  glb_re_b,
    output logic [ADDR-1:0]       glb_addr_b,
    input  logic [DATA_WIDTH-1:0] glb_rdata_b,
`ifdef PSUM_WRITER_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  busy,
    output logic                  done
);
    localparam int LANES = FIFO_WIDTH / DATA_WIDTH;
    localparam int LW    = $clog2(LANES) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RD, WR, FIN} state_t;

    state_t                  state, nxt;
    logic [ADDR-1:0]         base_q, num_q, idx, idx_n;
    logic                    acc_q;
    logic [LW-1:0]           lane, lane_n;
    logic [FIFO_WIDTH-1:0]   word_q, src_word;
    logic [DATA_WIDTH-1:0]   lane_q, lane_d, sum;
    logic [ADDR-1:0]         addr_d;
    logic                    accept, last_psum, last_lane;
    logic                    re_d, we_d, rb_d, busy_d, done_d;

    assign accept    = (state == IDLE) && start;
    assign last_psum = (idx + 1'b1) == num_q;
    assign last_lane = lane == LW'(LANES - 1);

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (num_psums == '0) ? FIN : FETCH;
            FETCH:   if (fifo_re) nxt = LOAD;
            LOAD:    nxt = acc_q ? RD : WR;
            RD:      nxt = WR;
            WR: begin
                if (last_psum)      nxt = FIN;
                else if (last_lane) nxt = FETCH;
                else                nxt = acc_q ? RD : WR;
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Output logic: next-cycle values of the registered strobes and buses.
    // Decoding from nxt makes each strobe high during the state it belongs to.
    always_comb begin
        idx_n  = idx;
        lane_n = lane;
        if (accept) begin
            idx_n  = '0;
            lane_n = '0;
        end else if (state == WR) begin
            idx_n  = idx + 1'b1;
            lane_n = last_lane ? '0 : lane + 1'b1;
        end
        // The word buffer is loaded on the same edge as the first lane is
        // selected, so bypass straight from the FIFO while in LOAD.
        src_word = (state == LOAD) ? fifo_rdata : word_q;
        lane_d   = src_word[int'(lane_n) * DATA_WIDTH +: DATA_WIDTH];
        addr_d   = base_q + idx_n;
        // fifo_empty is looked at one cycle ahead: only this block pops the
        // FIFO, so a non-empty flag cannot drop before the pop lands.
        re_d     = (nxt == FETCH) && !fifo_empty;
        we_d     = (nxt == WR);
        rb_d     = (nxt == RD);
        busy_d   = (nxt == FETCH) || (nxt == LOAD) || (nxt == RD) || (nxt == WR);
        done_d   = (nxt == FIN);
    end

    // State register, job context and registered outputs
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            acc_q      <= 1'b0;
            idx        <= '0;
            lane       <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            fifo_re    <= 1'b0;
            glb_we_a   <= 1'b0;
            glb_addr_a <= '0;
            glb_re_b   <= 1'b0;
            glb_addr_b <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= nxt;
            idx   <= idx_n;
            lane  <= lane_n;
            if (accept) begin
                base_q <= base_addr;
                num_q  <= num_psums;
                acc_q  <= accumulate;
            end
            if (state == LOAD) word_q <= fifo_rdata;
            fifo_re    <= re_d;
            glb_we_a   <= we_d;
            glb_addr_a <= we_d ? addr_d : '0;
            lane_q     <= we_d ? lane_d : '0;
            glb_re_b   <= rb_d;
            glb_addr_b <= rb_d ? addr_d : '0;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Read data only arrives in the WR cycle, so the add sits between the
    // registered lane operand and the write data bus.
`ifdef PSUM_WRITER_SAT_EN
    logic signed [DATA_WIDTH:0] wide;
    logic                       ovf;
    always_comb begin
        wide = {lane_q[DATA_WIDTH-1], lane_q} + {glb_rdata_b[DATA_WIDTH-1], glb_rdata_b};
        ovf  = wide[DATA_WIDTH] != wide[DATA_WIDTH-1];
        if (!ovf)                 sum = wide[DATA_WIDTH-1:0];
        else if (wide[DATA_WIDTH]) sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                       sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset)                          sat_flag <= 1'b0;
        else if (accept)                    sat_flag <= 1'b0;
        else if (glb_we_a && acc_q && ovf)  sat_flag <= 1'b1;
    end
`else
    assign sum = lane_q + glb_rdata_b;
`endif

    always_comb begin
        glb_wdata_a = '0;
        if (glb_we_a) glb_wdata_a = acc_q ? sum : lane_q;
    end
endmodule

// File: tb/tb_psum_glb_writer.sv
// Bench for psum_glb_writer: directed jobs plus randomized jobs, each checked
// against expected write streams computed from the packed words and GLB image.
module tb_psum_glb_writer;
    localparam int FW = 64;
    localparam int DW = 16;
    localparam int DEPTH = 193600;
    localparam int AW = $clog2(DEPTH);
    localparam int L = FW / DW;

    logic          core_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_psums = '0;
    logic          accumulate = 1'b0;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rdata = '0;
    logic          fifo_re;
    logic          glb_we_a;
    logic [AW-1:0] glb_addr_a;
    logic [DW-1:0] glb_wdata_a;
    logic          glb_re_b;
    logic [AW-1:0] glb_addr_b;
    logic [DW-1:0] glb_rdata_b = '0;
    logic          busy;
    logic          done;
`ifdef PSUM_WRITER_SAT_EN
    logic          sat_flag;
`endif

    psum_glb_writer #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .core_clk(core_clk), .reset(reset), .start(start),
        .base_addr(base_addr), .num_psums(num_psums), .accumulate(accumulate),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_re(fifo_re),
        .glb_we_a(glb_we_a), .glb_addr_a(glb_addr_a), .glb_wdata_a(glb_wdata_a),
        .glb_re_b(glb_re_b), .glb_addr_b(glb_addr_b), .glb_rdata_b(glb_rdata_b),
`ifdef PSUM_WRITER_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy), .done(done)
    );

    always #5 core_clk = ~core_clk;

    // ---------------- environment: FIFO and GLB ----------------
    logic [FW-1:0] fifo_mem [0:255];
    int            pushed = 0, popped = 0;
    logic          stall = 1'b0;
    assign fifo_empty = stall || (pushed == popped);

    logic [DW-1:0] pre_mem [0:1023];
    logic [DW-1:0] mem     [0:1023];
    int            wr_gen  [0:1023] = '{default: -1};
    int            job_id = 0;
    bit            job_acc = 1'b0;
    int            wlog_a [0:1023];
    logic [DW-1:0] wlog_d [0:1023];
    int            wcnt = 0, rcnt = 0, viol = 0, cyc = 0;
    logic          prev_re = 1'b0;
    logic [AW-1:0] prev_raddr = '0;

    always @(posedge core_clk) begin
        cyc <= cyc + 1;
        if (fifo_re) begin
            if (pushed == popped) viol <= viol + 1;
            fifo_rdata <= fifo_mem[popped % 256];
            popped <= popped + 1;
        end
        if (glb_re_b) begin
            glb_rdata_b <= (wr_gen[glb_addr_b[9:0]] == job_id) ? mem[glb_addr_b[9:0]]
                                                                : pre_mem[glb_addr_b[9:0]];
            rcnt <= rcnt + 1;
        end
        if (glb_we_a) begin
            mem[glb_addr_a[9:0]]    <= glb_wdata_a;
            wr_gen[glb_addr_a[9:0]] <= job_id;
            wlog_a[wcnt % 1024]     <= int'(glb_addr_a);
            wlog_d[wcnt % 1024]     <= glb_wdata_a;
            wcnt <= wcnt + 1;
            if (job_acc && !(prev_re && prev_raddr == glb_addr_a)) viol <= viol + 1;
            if (glb_re_b) viol <= viol + 1;
        end
        prev_re    <= glb_re_b;
        prev_raddr <= glb_addr_b;
    end

    // ---------------- checking ----------------
    int checks = 0, failures = 0;
    logic [FW-1:0] jw [0:15];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected accumulate result from the signed-arithmetic rule.
    function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef PSUM_WRITER_SAT_EN
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
`else
        return a + b;
`endif
    endfunction

    // Runs one job whose words are in jw[] and whose GLB pre-image is pre_mem,
    // then compares the observed write stream with the expected one.
    task automatic run_job(input int base, input int num, input int acc,
                           input int stall_n, input int mid, output int done_rel);
        int nw, s, p0, w0, v0, r0, k;
        bit got_done;
        logic [DW-1:0] lane_v, exp;
        nw = (num + L - 1) / L;
        job_id++;
        job_acc = (acc != 0);
        for (int i = 0; i < nw; i++) begin
            fifo_mem[pushed % 256] = jw[i];
            pushed++;
        end
        p0 = popped; w0 = wcnt; v0 = viol; r0 = rcnt;
        stall = (stall_n > 0);
        base_addr = AW'(base); num_psums = AW'(num); accumulate = (acc != 0);
        start = 1'b1;
        s = cyc;
        @(negedge core_clk);
        start = 1'b0;
        base_addr = AW'($urandom_range(0, 1023));
        num_psums = AW'($urandom_range(0, 1023));
        accumulate = (acc == 0);
        check("busy_after_start", busy, num != 0);
        if (stall_n > 0) begin
            for (int c = 0; c < stall_n; c++) begin
                check("stall_quiet", {fifo_re, glb_we_a, glb_re_b}, 3'b000);
                @(negedge core_clk);
            end
            stall = 1'b0;
            @(negedge core_clk);
            check("stall_resume", fifo_re, 1'b1);
        end
        got_done = 1'b0;
        k = 0;
        while (!got_done && k < 3000) begin
            if (done) got_done = 1'b1;
            else begin
                if (mid != 0 && k == 3) begin
                    start = 1'b1;
                    base_addr = AW'(777);
                    num_psums = AW'(3);
                end
                if (k == 4) start = 1'b0;
                @(negedge core_clk);
                k++;
            end
        end
        start = 1'b0;
        done_rel = cyc - s;
        check("done_seen", got_done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        @(negedge core_clk);
        check("done_one_cycle", done, 1'b0);
        check("write_count", wcnt - w0, num);
        check("pop_count", popped - p0, nw);
        check("protocol_viol", viol - v0, 0);
        check("read_count", rcnt - r0, (acc != 0) ? num : 0);
        for (int i = 0; i < num && i < wcnt - w0; i++) begin
            lane_v = jw[i / L][(i % L) * DW +: DW];
            exp = (acc != 0) ? model_sum(pre_mem[base + i], lane_v) : lane_v;
            check("waddr", wlog_a[(w0 + i) % 1024], base + i);
            check("wdata", wlog_d[(w0 + i) % 1024], exp);
        end
    endtask

    initial begin
        int d, b, n, a, w0;
        bit seen;
        repeat (3) @(negedge core_clk);
        check("rst_fifo_re", fifo_re, 1'b0);
        check("rst_we_a", glb_we_a, 1'b0);
        check("rst_re_b", glb_re_b, 1'b0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_buses", {glb_addr_a, glb_addr_b, glb_wdata_a}, '0);
        reset = 1'b0;
        @(negedge core_clk);

        // overwrite, single word
        jw[0] = 64'h0004_0003_0002_0001;
        run_job(100, 4, 0, 0, 0, d);
        check("t1_done_cycle", d, 7);

        // accumulate with wrap
        pre_mem[0] = 16'd10;
        pre_mem[1] = 16'hFFFF;
        jw[0] = 64'h0000_0000_0001_0005;
        w0 = wcnt;
        run_job(0, 2, 1, 0, 0, d);
        check("t2_done_cycle", d, 7);
        check("t2_sum0", wlog_d[w0 % 1024], 16'd15);
        check("t2_sum1", wlog_d[(w0 + 1) % 1024], 16'h0000);
`ifdef PSUM_WRITER_SAT_EN
        check("t2_no_sat", sat_flag, 1'b0);
`endif

        // partial last word, with a start pulse mid-transfer
        jw[0] = {$urandom, $urandom};
        jw[1] = {$urandom, $urandom};
        run_job(200, 6, 0, 0, 1, d);

        // FIFO stall for 5 cycles in FETCH
        jw[0] = {$urandom, $urandom};
        run_job(400, 4, 0, 5, 0, d);
        check("t4_done_cycle", d, 13);

        // zero-length job
        run_job(500, 0, 0, 0, 0, d);
        check("t5_done_cycle", d, 1);

        // async reset in the middle of a 16-psum job
        for (int i = 0; i < 4; i++) begin
            fifo_mem[pushed % 256] = {$urandom, $urandom};
            pushed++;
        end
        job_id++;
        job_acc = 1'b0;
        w0 = wcnt;
        base_addr = AW'(300); num_psums = AW'(16); accumulate = 1'b0;
        start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge core_clk);
            seen = glb_we_a && (wcnt - w0 >= 5);
        end
        check("t6_mid_write", seen, 1'b1);
        @(posedge core_clk);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_strobes", {fifo_re, glb_we_a, glb_re_b, busy, done}, 5'b0);
        check("t6_rst_buses", {glb_addr_a, glb_addr_b, glb_wdata_a}, '0);
        @(negedge core_clk);
        reset = 1'b0;
        pushed = popped;
        @(negedge core_clk);
        check("t6_idle_after", busy, 1'b0);
        for (int i = 0; i < 4; i++) jw[i] = {$urandom, $urandom};
        run_job(300, 16, 0, 0, 0, d);

        // randomized jobs
        for (int t = 0; t < 8; t++) begin
            b = $urandom_range(0, 900);
            n = $urandom_range(1, 16);
            a = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) jw[i] = {$urandom, $urandom};
            for (int i = 0; i < n; i++) pre_mem[b + i] = DW'($urandom);
            run_job(b, n, a, 0, 0, d);
            check("rand_done_cycle", d, 1 + ((n + L - 1) / L) * 2 + n * ((a != 0) ? 2 : 1));
        end

`ifdef PSUM_WRITER_SAT_EN
        pre_mem[900] = 16'h7FFF;
        pre_mem[901] = 16'h8000;
        jw[0] = 64'h0000_0000_FFFF_0001;
        w0 = wcnt;
        run_job(900, 2, 1, 0, 0, d);
        check("sat_pos", wlog_d[w0 % 1024], 16'h7FFF);
        check("sat_neg", wlog_d[(w0 + 1) % 1024], 16'h8000);
        check("sat_flag", sat_flag, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
